// File: rtl/simple_graph_monitor_pkg.sv
// Shared types and sizes for the four-stream graph monitor.
// All stream arithmetic is signed two's complement that wraps on overflow.
package simple_graph_monitor_pkg;

    localparam int DATA_WIDTH  = 64;
    localparam int QUEUE_DEPTH = 4;
    localparam int NUM_STREAMS = 4;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    // IDLE accepts a pop; L0..L2 compute one dependency layer each.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L0   = 2'd1,
        L1   = 2'd2,
        L2   = 2'd3
    } eval_state_t;

endpackage

// File: rtl/simple_graph_monitor_event_queue.sv
// Synchronous input-event FIFO with registered read data.
// Pointers carry one extra wrap bit so full and empty need no counter.
module simple_graph_monitor_event_queue
    import simple_graph_monitor_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH,
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    // DEPTH must be a power of two for the wrap-bit comparison to hold.
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic [WIDTH-1:0] pop_data_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_data = pop_data_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            pop_data_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                pop_data_reg <= mem[rd_ptr_reg[PTR_W-1:0]];
                rd_ptr_reg   <= rd_ptr_reg + (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/simple_graph_monitor.sv
// Runtime monitor: queues input events and evaluates the four dependent
// streams one layer per cycle, pulsing all aktv flags when output_3 lands.
module simple_graph_monitor
    import simple_graph_monitor_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  sample_t input_0,
    input  logic    new_input_0,
    output sample_t output_0,
    output sample_t output_1,
    output sample_t output_2,
    output sample_t output_3,
    output logic    output_0_aktv,
    output logic    output_1_aktv,
    output logic    output_2_aktv,
    output logic    output_3_aktv,
    output logic    q_push,
    output logic    q_pop,
    output logic    q_push_valid,
    output logic    q_pop_valid,
    output logic    pacing_0,
    output logic    pacing_1,
    output logic    pacing_2,
    output logic    pacing_3
);

    localparam sample_t ONE = sample_t'(1);

    logic        full;
    logic        empty;
    sample_t     sample;
    eval_state_t state_reg;
    sample_t     out_reg [NUM_STREAMS];
    logic        aktv_reg;

    logic [NUM_STREAMS-1:0] aktv_vec;
    logic [NUM_STREAMS-1:0] pacing_vec;

    assign q_push       = new_input_0 && en;
    assign q_pop        = en && (state_reg == IDLE);
    assign q_push_valid = q_push && !full;
    assign q_pop_valid  = q_pop && !empty;

    // The queue's registered read doubles as the evaluator's sample latch (E1).
    simple_graph_monitor_event_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_event_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push_valid),
        .push_data (input_0),
        .pop       (q_pop_valid),
        .pop_data  (sample),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            aktv_reg  <= 1'b0;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                out_reg[i] <= '0;
            end
        end else if (en) begin
            aktv_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (q_pop_valid) begin
                        state_reg <= L0;
                    end
                end
                L0: begin
                    out_reg[0] <= sample + ONE;
                    state_reg  <= L1;
                end
                L1: begin
                    out_reg[1] <= out_reg[0] + ONE;
                    out_reg[2] <= out_reg[0] + out_reg[0];
                    state_reg  <= L2;
                end
                L2: begin
                    out_reg[3] <= out_reg[1] + out_reg[2];
                    aktv_reg   <= 1'b1;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // A pulse caught by en going low is held and shown once en returns.
    for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_flags
        assign aktv_vec[gi]   = aktv_reg && en;
        assign pacing_vec[gi] = q_pop_valid;
    end

    assign output_0      = out_reg[0];
    assign output_1      = out_reg[1];
    assign output_2      = out_reg[2];
    assign output_3      = out_reg[3];
    assign output_0_aktv = aktv_vec[0];
    assign output_1_aktv = aktv_vec[1];
    assign output_2_aktv = aktv_vec[2];
    assign output_3_aktv = aktv_vec[3];
    assign pacing_0      = pacing_vec[0];
    assign pacing_1      = pacing_vec[1];
    assign pacing_2      = pacing_vec[2];
    assign pacing_3      = pacing_vec[3];

endmodule

// File: tb/tb_simple_graph_monitor.sv
// Randomised scoreboard bench for simple_graph_monitor against a
// transaction-level queue/evaluator model kept in the bench.
module tb_simple_graph_monitor;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [63:0] input_0;
    logic               new_input_0;
    logic signed [63:0] output_0, output_1, output_2, output_3;
    logic               output_0_aktv, output_1_aktv, output_2_aktv, output_3_aktv;
    logic               q_push, q_pop, q_push_valid, q_pop_valid;
    logic               pacing_0, pacing_1, pacing_2, pacing_3;

    always #5 clk = ~clk;

    simple_graph_monitor dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .input_0       (input_0),
        .new_input_0   (new_input_0),
        .output_0      (output_0),
        .output_1      (output_1),
        .output_2      (output_2),
        .output_3      (output_3),
        .output_0_aktv (output_0_aktv),
        .output_1_aktv (output_1_aktv),
        .output_2_aktv (output_2_aktv),
        .output_3_aktv (output_3_aktv),
        .q_push        (q_push),
        .q_pop         (q_pop),
        .q_push_valid  (q_push_valid),
        .q_pop_valid   (q_pop_valid),
        .pacing_0      (pacing_0),
        .pacing_1      (pacing_1),
        .pacing_2      (pacing_2),
        .pacing_3      (pacing_3)
    );

    typedef struct {
        longint o0;
        longint o1;
        longint o2;
        longint o3;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   got_e;
    int     checks = 0;
    int     passes = 0;

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s: got %0d required %0d", name, got, want);
    endtask

    // Stream equations composed directly from the input value.
    function automatic exp_t reference(input longint v);
        exp_t e;
        e.o0 = v + 1;
        e.o1 = e.o0 + 1;
        e.o2 = e.o0 * 2;
        e.o3 = e.o1 + e.o2;
        return e;
    endfunction

    // Monitor: consumes one expected result per aktv pulse.
    always @(negedge clk) begin
        if (output_0_aktv) begin
            check("aktv_flags", {output_3_aktv, output_2_aktv, output_1_aktv}, 3'b111);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                got_e = exp_q.pop_front();
                $display("pulse: o0=%0d o1=%0d o2=%0d o3=%0d", output_0, output_1, output_2, output_3);
                check("output_0", output_0, got_e.o0);
                check("output_1", output_1, got_e.o1);
                check("output_2", output_2, got_e.o2);
                check("output_3", output_3, got_e.o3);
            end
        end
    end

    // Cycle model: queued values, cycles left until the evaluator frees up,
    // and whether a result pulse is due this cycle.
    longint mq[$];
    int     busy = 0;
    bit     pulse = 1'b0;
    bit     rst_seen = 1'b0;
    bit     push_ok, pop_ok;

    always begin
        @(negedge clk);
        #1;
        push_ok = new_input_0 && en && (mq.size() < 4);
        pop_ok  = en && (busy == 0) && (mq.size() > 0);
        check("q_push", q_push, new_input_0 && en);
        check("q_push_valid", q_push_valid, push_ok);
        check("q_pop", q_pop, en && (busy == 0));
        check("q_pop_valid", q_pop_valid, pop_ok);
        check("pacing", {pacing_3, pacing_2, pacing_1, pacing_0}, {4{pop_ok}});
        check("aktv_timing", {output_3_aktv, output_2_aktv, output_1_aktv, output_0_aktv},
              {4{pulse && en}});
        if (rst_seen) begin
            check("rst_outputs", output_0 | output_1 | output_2 | output_3, 0);
            rst_seen = 1'b0;
        end
        if (rst) begin
            mq.delete();
            exp_q.delete();
            busy = 0;
            pulse = 1'b0;
            rst_seen = 1'b1;
        end else if (en) begin
            pulse = (busy == 1);
            if (pop_ok) begin
                void'(mq.pop_front());
                busy = 3;
            end else if (busy > 0) begin
                busy--;
            end
            if (push_ok) begin
                mq.push_back(input_0);
                exp_q.push_back(reference(input_0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input longint v);
        input_0     = v;
        new_input_0 = 1'b1;
        tick();
        new_input_0 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        input_0 = '0;
        new_input_0 = 1'b0;
        tick();
        rst = 1'b0;
        idle(50);
        check("idle_outputs", output_0 | output_1 | output_2 | output_3, 0);

        en = 1'b1;
        for (int v = 1; v <= 6; v++) begin
            send(longint'(v));
            idle(49);
        end

        for (int v = 1; v <= 8; v++) send(longint'(v));
        idle(60);

        send(64'sh7FFF_FFFF_FFFF_FFFF);
        idle(20);

        send(10);
        idle(2);
        en = 1'b0;
        idle(10);
        en = 1'b1;
        idle(20);

        send(100);
        send(200);
        send(300);
        idle(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(30);
        check("post_rst_outputs", output_0 | output_1 | output_2 | output_3, 0);

        for (int i = 0; i < 400; i++) begin
            en          = ($urandom_range(9) != 0);
            new_input_0 = ($urandom_range(2) == 0);
            input_0     = {$urandom, $urandom};
            tick();
        end
        new_input_0 = 1'b0;
        en = 1'b1;
        idle(80);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
